// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch and
// data-access requesters. One transaction is outstanding at a time; the
// response is routed back to its owner, and a watchdog turns a memory that
// never completes into an error response.
//
// state | meaning
// IDLE  | nothing outstanding; arbitrate and grant a pending request
// BUSY  | m_* presented to memory, waiting for m_valid or the watchdog
// RESP  | one-cycle valid pulse to the owning requester
module mem_arbiter #(
    parameter int DATA_PRIORITY = 0,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_request,
    input  logic        i_we_re,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_request,
    input  logic        d_we_re,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        m_request,
    output logic        m_we_re,
    output logic [3:0]  m_mask,
    output logic [31:0] m_address,
    output logic [31:0] m_wdata,
    input  logic        m_valid,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Watchdog limit; the counter counts completed BUSY cycles.
    localparam int         TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [7:0] TO_LAST   = 8'(TO_LAST_I);
    localparam bit         TO_EN     = (TIMEOUT != 0);
    localparam bit         D_PRIO    = (DATA_PRIORITY != 0);

    // Owner / last_grant encoding: 1 = data requester, 0 = instruction.
    state_t      state_q,      state_d;
    logic        owner_q,      owner_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        m_request_q,  m_request_d;
    logic        m_we_re_q,    m_we_re_d;
    logic [3:0]  m_mask_q,     m_mask_d;
    logic [31:0] m_address_q,  m_address_d;
    logic [31:0] m_wdata_q,    m_wdata_d;
    logic        i_valid_q,    i_valid_d;
    logic [31:0] i_rdata_q,    i_rdata_d;
    logic        i_err_q,      i_err_d;
    logic        d_valid_q,    d_valid_d;
    logic [31:0] d_rdata_q,    d_rdata_d;
    logic        d_err_q,      d_err_d;
    logic        gnt_data;

    // Next-state logic: arbitration, memory-port capture, completion/watchdog.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_request_d  = m_request_q;
        m_we_re_d    = m_we_re_q;
        m_mask_d     = m_mask_q;
        m_address_d  = m_address_q;
        m_wdata_d    = m_wdata_q;
        // Response outputs are pulses; they fall back to zero unless set below.
        i_valid_d    = 1'b0;
        i_rdata_d    = 32'h0;
        i_err_d      = 1'b0;
        d_valid_d    = 1'b0;
        d_rdata_d    = 32'h0;
        d_err_d      = 1'b0;
        // Data wins when alone, when it has fixed priority, or when the
        // instruction side was served last.
        gnt_data     = d_request && (!i_request || D_PRIO || !last_grant_q);

        case (state_q)
            S_IDLE: begin
                if (i_request || d_request) begin
                    owner_d      = gnt_data;
                    last_grant_d = gnt_data;
                    cnt_d        = 8'h0;
                    m_request_d  = 1'b1;
                    m_we_re_d    = gnt_data ? d_we_re   : i_we_re;
                    m_mask_d     = gnt_data ? d_mask    : i_mask;
                    m_address_d  = gnt_data ? d_address : i_address;
                    m_wdata_d    = gnt_data ? d_wdata   : i_wdata;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                // Completion is checked first so it beats a same-cycle timeout.
                if (m_valid) begin
                    m_request_d = 1'b0;
                    state_d     = S_RESP;
                    if (owner_q) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = m_rdata;
                    end else begin
                        i_valid_d = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    m_request_d = 1'b0;
                    state_d     = S_RESP;
                    if (owner_q) begin
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        i_valid_d = 1'b1;
                        i_err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'h0;
            m_request_q  <= 1'b0;
            m_we_re_q    <= 1'b0;
            m_mask_q     <= 4'h0;
            m_address_q  <= 32'h0;
            m_wdata_q    <= 32'h0;
            i_valid_q    <= 1'b0;
            i_rdata_q    <= 32'h0;
            i_err_q      <= 1'b0;
            d_valid_q    <= 1'b0;
            d_rdata_q    <= 32'h0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_request_q  <= m_request_d;
            m_we_re_q    <= m_we_re_d;
            m_mask_q     <= m_mask_d;
            m_address_q  <= m_address_d;
            m_wdata_q    <= m_wdata_d;
            i_valid_q    <= i_valid_d;
            i_rdata_q    <= i_rdata_d;
            i_err_q      <= i_err_d;
            d_valid_q    <= d_valid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    assign m_request = m_request_q;
    assign m_we_re   = m_we_re_q;
    assign m_mask    = m_mask_q;
    assign m_address = m_address_q;
    assign m_wdata   = m_wdata_q;
    assign i_valid   = i_valid_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (round-robin with the default
// watchdog, and data-priority with a 4-cycle watchdog), each with its own
// expected-response queue checked by an independent monitor.
module tb_mem_arbiter;

    typedef struct packed {
        logic        src;    // 1 = data requester
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int resp_a   = 0;
    int resp_b   = 0;
    rsp_t q_a[$];
    rsp_t q_b[$];
    rsp_t exp_a, exp_b;

    // ---------------- instance A: round-robin, TIMEOUT 255 ----------------
    logic        rst_a = 1'b1;
    logic        a_i_request = 0, a_i_we_re = 0;
    logic [3:0]  a_i_mask = 0;
    logic [31:0] a_i_address = 0, a_i_wdata = 0;
    logic        a_i_valid, a_i_err;
    logic [31:0] a_i_rdata;
    logic        a_d_request = 0, a_d_we_re = 0;
    logic [3:0]  a_d_mask = 0;
    logic [31:0] a_d_address = 0, a_d_wdata = 0;
    logic        a_d_valid, a_d_err;
    logic [31:0] a_d_rdata;
    logic        a_m_request, a_m_we_re, a_m_valid;
    logic [3:0]  a_m_mask;
    logic [31:0] a_m_address, a_m_wdata, a_m_rdata;
    logic        a_auto = 0, a_mv_man = 0;
    logic [31:0] a_rd_man = 0;

    // Auto mode: memory answers in the first BUSY cycle with ~address.
    assign a_m_valid = a_mv_man | (a_auto & a_m_request);
    assign a_m_rdata = a_auto ? ~a_m_address : a_rd_man;

    mem_arbiter #(.DATA_PRIORITY(0), .TIMEOUT(255)) ua (
        .clk(clk), .rst(rst_a),
        .i_request(a_i_request), .i_we_re(a_i_we_re), .i_mask(a_i_mask),
        .i_address(a_i_address), .i_wdata(a_i_wdata),
        .i_valid(a_i_valid), .i_rdata(a_i_rdata), .i_err(a_i_err),
        .d_request(a_d_request), .d_we_re(a_d_we_re), .d_mask(a_d_mask),
        .d_address(a_d_address), .d_wdata(a_d_wdata),
        .d_valid(a_d_valid), .d_rdata(a_d_rdata), .d_err(a_d_err),
        .m_request(a_m_request), .m_we_re(a_m_we_re), .m_mask(a_m_mask),
        .m_address(a_m_address), .m_wdata(a_m_wdata),
        .m_valid(a_m_valid), .m_rdata(a_m_rdata)
    );

    // ---------------- instance B: data priority, TIMEOUT 4 ----------------
    logic        rst_b = 1'b1;
    logic        b_i_request = 0, b_i_we_re = 0;
    logic [3:0]  b_i_mask = 0;
    logic [31:0] b_i_address = 0, b_i_wdata = 0;
    logic        b_i_valid, b_i_err;
    logic [31:0] b_i_rdata;
    logic        b_d_request = 0, b_d_we_re = 0;
    logic [3:0]  b_d_mask = 0;
    logic [31:0] b_d_address = 0, b_d_wdata = 0;
    logic        b_d_valid, b_d_err;
    logic [31:0] b_d_rdata;
    logic        b_m_request, b_m_we_re, b_m_valid;
    logic [3:0]  b_m_mask;
    logic [31:0] b_m_address, b_m_wdata, b_m_rdata;
    logic        b_auto = 0, b_mv_man = 0;
    logic [31:0] b_rd_man = 0;

    assign b_m_valid = b_mv_man | (b_auto & b_m_request);
    assign b_m_rdata = b_auto ? ~b_m_address : b_rd_man;

    mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT(4)) ub (
        .clk(clk), .rst(rst_b),
        .i_request(b_i_request), .i_we_re(b_i_we_re), .i_mask(b_i_mask),
        .i_address(b_i_address), .i_wdata(b_i_wdata),
        .i_valid(b_i_valid), .i_rdata(b_i_rdata), .i_err(b_i_err),
        .d_request(b_d_request), .d_we_re(b_d_we_re), .d_mask(b_d_mask),
        .d_address(b_d_address), .d_wdata(b_d_wdata),
        .d_valid(b_d_valid), .d_rdata(b_d_rdata), .d_err(b_d_err),
        .m_request(b_m_request), .m_we_re(b_m_we_re), .m_mask(b_m_mask),
        .m_address(b_m_address), .m_wdata(b_m_wdata),
        .m_valid(b_m_valid), .m_rdata(b_m_rdata)
    );

    // ---------------- helpers ----------------
    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic rsp_t mk_rsp(input logic src, input logic [31:0] rdata,
                                    input logic err);
        rsp_t r;
        r.src = src;
        r.rdata = rdata;
        r.err = err;
        return r;
    endfunction

    task automatic set_req_a(input bit is_d, input bit req, input bit we,
                             input logic [3:0] mask, input logic [31:0] addr,
                             input logic [31:0] wdata);
        if (is_d) begin
            a_d_request = req; a_d_we_re = we; a_d_mask = mask;
            a_d_address = addr; a_d_wdata = wdata;
        end else begin
            a_i_request = req; a_i_we_re = we; a_i_mask = mask;
            a_i_address = addr; a_i_wdata = wdata;
        end
    endtask

    task automatic reset_a();
        @(posedge clk); #1 rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    task automatic reset_b();
        @(posedge clk); #1 rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
    endtask

    // One transaction on instance A: request at cycle 0, m_valid at cycle dly.
    // The memory port must hold the request fields through cycle dly, and the
    // owner sees exactly one valid pulse at cycle dly+1.
    task automatic txn_a(input bit is_d, input bit we, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int dly,
                         input string name);
        int vcyc, pulses, bad;
        logic own, oth;
        vcyc = -1; pulses = 0; bad = 0;
        q_a.push_back(mk_rsp(is_d, rdata, 1'b0));
        @(posedge clk); #1;
        set_req_a(is_d, 1'b1, we, mask, addr, wdata);
        for (int c = 1; c <= dly + 3; c++) begin
            @(posedge clk); #1;
            a_mv_man = (c == dly);
            a_rd_man = (c == dly) ? rdata : 32'h0;
            if (c == dly + 2) set_req_a(is_d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (c <= dly && !(a_m_request && a_m_address == addr && a_m_we_re == we
                              && a_m_mask == mask && a_m_wdata == wdata)) bad++;
            if (c == dly + 1 && a_m_request) bad++;
            own = is_d ? a_d_valid : a_i_valid;
            oth = is_d ? a_i_valid : a_d_valid;
            if (own) begin
                pulses++;
                if (vcyc < 0) vcyc = c;
            end
            if (oth) bad++;
        end
        chk(bad == 0, {name, " memory port"}, 32'(bad), 32'h0);
        chk(pulses == 1 && vcyc == dly + 1, {name, " response cycle"},
            32'(vcyc), 32'(dly + 1));
    endtask

    // Watchdog run on instance B (limit 4): request at cycle 0; with hit set,
    // m_valid arrives in the limit cycle (4). Response expected at cycle 5.
    task automatic tmo_b(input bit hit, input logic [31:0] addr, input string name);
        int vcyc;
        bit mreq_late;
        vcyc = -1; mreq_late = 0;
        q_b.push_back(hit ? mk_rsp(1'b0, 32'hCAFEF00D, 1'b0)
                          : mk_rsp(1'b0, 32'h0, 1'b1));
        @(posedge clk); #1;
        b_i_request = 1'b1; b_i_address = addr;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            b_mv_man = hit && (c == 4);
            b_rd_man = (hit && c == 4) ? 32'hCAFEF00D : 32'hFFFFFFFF;
            if (c == 6) b_i_request = 1'b0;
            @(negedge clk);
            if (b_i_valid && vcyc < 0) vcyc = c;
            if (c >= 5 && b_m_request) mreq_late = 1;
        end
        b_rd_man = 32'h0;
        chk(vcyc == 5, {name, " response cycle"}, 32'(vcyc), 32'd5);
        chk(!mreq_late, {name, " back to idle"}, 32'(mreq_late), 32'h0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_i_valid || a_d_valid) begin
            if (a_i_valid && a_d_valid) begin
                chk(1'b0, "A both valid", 32'h3, 32'h1);
            end else if (q_a.size() == 0) begin
                chk(1'b0, "A unexpected response", a_i_valid ? a_i_rdata : a_d_rdata, 32'h0);
            end else begin
                exp_a = q_a.pop_front();
                chk(a_d_valid == exp_a.src, "A owner", 32'(a_d_valid), 32'(exp_a.src));
                chk((exp_a.src ? a_d_rdata : a_i_rdata) == exp_a.rdata, "A rdata",
                    exp_a.src ? a_d_rdata : a_i_rdata, exp_a.rdata);
                chk((exp_a.src ? a_d_err : a_i_err) == exp_a.err, "A err",
                    32'(exp_a.src ? a_d_err : a_i_err), 32'(exp_a.err));
            end
            resp_a++;
        end
    end

    always @(negedge clk) begin
        if (b_i_valid || b_d_valid) begin
            if (b_i_valid && b_d_valid) begin
                chk(1'b0, "B both valid", 32'h3, 32'h1);
            end else if (q_b.size() == 0) begin
                chk(1'b0, "B unexpected response", b_i_valid ? b_i_rdata : b_d_rdata, 32'h0);
            end else begin
                exp_b = q_b.pop_front();
                chk(b_d_valid == exp_b.src, "B owner", 32'(b_d_valid), 32'(exp_b.src));
                chk((exp_b.src ? b_d_rdata : b_i_rdata) == exp_b.rdata, "B rdata",
                    exp_b.src ? b_d_rdata : b_i_rdata, exp_b.rdata);
                chk((exp_b.src ? b_d_err : b_i_err) == exp_b.err, "B err",
                    32'(exp_b.src ? b_d_err : b_i_err), 32'(exp_b.err));
            end
            resp_b++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int start, bad;

        reset_a();
        reset_b();
        @(negedge clk);
        chk({a_m_request, a_m_we_re, a_m_mask, a_m_address, a_m_wdata} == '0,
            "reset memory port", a_m_address, 32'h0);
        chk({a_i_valid, a_i_err, a_i_rdata} == '0, "reset i outputs", a_i_rdata, 32'h0);
        chk({a_d_valid, a_d_err, a_d_rdata} == '0, "reset d outputs", a_d_rdata, 32'h0);

        // Single read, memory answers in the first BUSY cycle.
        txn_a(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1, "single read");

        // Data write with completion delayed 5 cycles past the first BUSY cycle.
        txn_a(1'b1, 1'b1, 4'b0011, 32'h80, 32'h1234, 32'h55, 6, "data write");

        // Both requesters held after reset: round-robin starts with instruction.
        reset_a();
        a_auto = 1'b1;
        q_a.push_back(mk_rsp(1'b0, ~32'h200, 1'b0));
        q_a.push_back(mk_rsp(1'b1, ~32'h300, 1'b0));
        q_a.push_back(mk_rsp(1'b0, ~32'h200, 1'b0));
        q_a.push_back(mk_rsp(1'b1, ~32'h300, 1'b0));
        start = resp_a;
        @(posedge clk); #1;
        set_req_a(1'b0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        set_req_a(1'b1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        for (int k = 0; k < 60 && resp_a < start + 4; k++) begin
            @(negedge clk); #1;
        end
        chk(resp_a == start + 4, "round-robin responses", 32'(resp_a - start), 32'd4);
        @(posedge clk); #1;
        set_req_a(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req_a(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 a_auto = 1'b0;

        // Reset while BUSY, then a late m_valid: nothing may come out.
        bad = 0;
        @(posedge clk); #1;
        set_req_a(1'b0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            rst_a = (c == 2);
            if (c == 2) set_req_a(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            a_mv_man = (c == 5);
            a_rd_man = (c == 5) ? 32'h11111111 : 32'h0;
            @(negedge clk);
            if (c >= 3 && ({a_m_request, a_m_we_re, a_m_mask, a_m_address, a_m_wdata,
                            a_i_valid, a_i_err, a_i_rdata,
                            a_d_valid, a_d_err, a_d_rdata} != '0)) bad++;
        end
        chk(bad == 0, "reset mid-busy outputs quiet", 32'(bad), 32'h0);
        txn_a(1'b0, 1'b0, 4'hF, 32'h700, 32'h0, 32'h77770000, 1, "post-reset read");

        // Stray m_valid in IDLE.
        bad = 0;
        @(posedge clk); #1;
        a_mv_man = 1'b1; a_rd_man = 32'hBAD0BAD0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            a_mv_man = 1'b0; a_rd_man = 32'h0;
            @(negedge clk);
            if (a_m_request || a_i_valid || a_d_valid) bad++;
        end
        chk(bad == 0, "stray valid ignored", 32'(bad), 32'h0);
        txn_a(1'b1, 1'b0, 4'hF, 32'h900, 32'h0, 32'h0BADCAFE, 2, "read after stray");

        // Instance B: fixed data priority, both requesters held.
        a_auto = 1'b0;
        b_auto = 1'b1;
        repeat (3) q_b.push_back(mk_rsp(1'b1, ~32'h300, 1'b0));
        start = resp_b;
        @(posedge clk); #1;
        b_i_request = 1'b1; b_i_address = 32'h200; b_i_mask = 4'hF;
        b_d_request = 1'b1; b_d_address = 32'h300; b_d_mask = 4'hF;
        for (int k = 0; k < 60 && resp_b < start + 3; k++) begin
            @(negedge clk); #1;
        end
        chk(resp_b == start + 3, "priority responses", 32'(resp_b - start), 32'd3);
        @(posedge clk); #1;
        b_i_request = 1'b0; b_d_request = 1'b0;
        repeat (3) @(posedge clk);
        #1 b_auto = 1'b0;

        // Watchdog: no completion, then completion in the limit cycle.
        reset_b();
        tmo_b(1'b0, 32'h400, "timeout");
        tmo_b(1'b1, 32'h404, "valid at limit");

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(q_a.size() == 0, "A all responses seen", 32'(q_a.size()), 32'h0);
        chk(q_b.size() == 0, "B all responses seen", 32'(q_b.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got %0d/%0d, expected completion", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between the core's instruction-fetch and data-access interfaces. The unified-memory build uses it in place of separate instruction and data memories. Each request is granted to the memory port and tracked until the memory returns `valid`. The response is then routed back to the requester that owns it. A watchdog ends any transaction the memory does not complete and reports an error.

## Interface
- `DATA_PRIORITY`, default 0: 1 = data always wins a tie; 0 = round-robin between requesters.
- `TIMEOUT`, default 255: number of BUSY cycles allowed before an error response; 0 disables the watchdog. Range 0..255.

Ports (direction, width, meaning). Clock and reset:
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.

Instruction requester port:
- `i_request` in 1: instruction request.
- `i_we_re` in 1: 1 = write, 0 = read.
- `i_mask` in 4: byte enables.
- `i_address` in 32: byte address.
- `i_wdata` in 32: write data.
- `i_valid` out 1: one-cycle response pulse.
- `i_rdata` out 32: read data; meaningful only while `i_valid` = 1.
- `i_err` out 1: timeout flag; meaningful only while `i_valid` = 1.

Data requester port:
- `d_request`, `d_we_re`, `d_mask`, `d_address`, `d_wdata`, `d_valid`, `d_rdata`, `d_err`: same widths and meanings as the `i_*` signals, for the data requester.

Memory port:
- `m_request` out 1: request to memory.
- `m_we_re` out 1: 1 = write, 0 = read.
- `m_mask` out 4: byte enables.
- `m_address` out 32: byte address.
- `m_wdata` out 32: write data.
- `m_valid` in 1: memory completion.
- `m_rdata` in 32: memory read data.

## Operation
- FSM states are IDLE, BUSY and RESP. Only one transaction is outstanding at any time.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high and `DATA_PRIORITY` = 1, grant data.
  - If both are high and `DATA_PRIORITY` = 0, grant the requester not in `last_grant`.
  - On a grant: register the winner's `we_re`, `mask`, `address` and `wdata` onto the `m_*` outputs. Set `m_request` = 1, set `owner` and `last_grant` to the winner, clear the timeout counter, and go to BUSY.
- **BUSY**
  - `m_request` and the other `m_*` outputs are held stable.
  - If `m_valid` = 1: latch `m_rdata`, set err = 0, clear `m_request`, and go to RESP.
  - Else if `TIMEOUT` ≠ 0 and counter = `TIMEOUT`−1: latch rdata = 0, set err = 1, clear `m_request`, and go to RESP.
  - Otherwise increment the counter and stay in BUSY.
  - When `m_valid` arrives in the same cycle the counter reaches its limit, completion wins and no error is reported.
- **RESP**
  - Assert `owner`'s `x_valid` for exactly one cycle, driving the latched rdata and err. The other requester's outputs stay 0.
  - Both request inputs are ignored. Next state is IDLE.
- Requester obligations:
  - Hold `request` and its fields stable until `x_valid` is seen.
  - Drop `request` in the cycle after `x_valid`, unless issuing a new transaction.
- `m_valid` is ignored in IDLE and RESP. A stray or late completion must never produce a response.
- Write transactions follow the same flow. rdata is whatever memory returns and the requester ignores it.
- Reset:
  - Any state goes to IDLE. `m_request`, all `x_valid`, `x_err` and all data and address outputs are 0, and the counter is 0.
  - `last_grant` = data, so with `DATA_PRIORITY` = 0 the first tie goes to instruction.
  - An in-flight transaction is abandoned; a subsequent `m_valid` is ignored.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request high in IDLE at cycle 0 gives `m_request` = 1 from cycle 1.
- `m_valid` at cycle k (k ≥ 1) gives `x_valid` at cycle k+1, and `m_request` = 0 from cycle k+1.
- Minimum latency from request to `x_valid` is 2 cycles. Maximum throughput is one transaction per 3 cycles.
- The timeout fires with `m_valid` never asserted: `x_valid` with err = 1 appears at cycle `TIMEOUT`+1.
- A requester kept waiting while the other is served is granted in the first IDLE cycle after that transaction. With round-robin, neither requester waits more than one transaction.

## Test plan
- **Single read:** `i_request` at cycle 0 (address 0x100), memory returns `m_valid` at cycle 1 with rdata 0xDEADBEEF. Required: `m_address` = 0x100 and `m_request` = 1 at cycle 1; `i_valid` = 1 and `i_rdata` = 0xDEADBEEF at cycle 2; `d_valid` stays 0.
- **Tie, round-robin:** with `DATA_PRIORITY` = 0, both requests held continuously after reset. Required: grant order is I, D, I, D. With `DATA_PRIORITY` = 1, the order is D, D, D.
- **Data write:** `d_we_re` = 1, `d_mask` = 4'b0011, wdata 0x1234. Required: `m_we_re`, `m_mask` and `m_wdata` match and stay stable while `m_valid` is delayed 5 cycles; `d_valid` pulses exactly once.
- **Timeout:** with `TIMEOUT` = 4, `m_valid` is never asserted. Required: `i_valid` = 1, `i_err` = 1 and `i_rdata` = 0 at cycle 5, then IDLE. Repeat with `m_valid` in the limit cycle: required err = 0 with normal data.
- **Reset mid-BUSY:** assert `rst` during BUSY, then `m_valid` arrives 2 cycles after reset. Required: all outputs are 0 and no `x_valid` is produced; a following request is served normally.
- **Stray valid:** `m_valid` pulsed in IDLE. Required: no `x_valid` and no state change.
